mirfak_mdu_ctrl: RTL and testbench
==================================

Name: mirfak_mdu_ctrl

Overview:
- Sequenced multi-cycle multiply/divide unit for the RV32M instructions that the decoder flags as M-extension ops.
- Sits in the execute stage. It accepts one operation at a time and iterates a shared shift/add-subtract datapath.
- Holds the pipeline with a stall signal until a single-cycle ack returns the 32-bit result.
- Supports flush (kill) at any point in the operation.

Parameters:
- ENABLE_MULTDIV, 1, when 0 the block never starts: stall_o=0, ack_o=0, result_o=0.
- FAST_DIV_CORNER, 1, enables 1-cycle completion for divide-by-zero and signed overflow. When 0, these cases take the full iterative latency but produce the same results.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active high.
- mdu_op_i  input  3  funct3 of the M instruction: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- mdu_dat1_i  input  32  rs1 operand.
- mdu_dat2_i  input  32  rs2 operand.
- mdu_enable_i  input  1  valid M op present in EX. Held high with stable op/operands until ack or kill.
- mdu_kill_i  input  1  pipeline flush. Aborts any operation in flight.
- mdu_result_o  output  32  result, valid when ack_o=1.
- mdu_ack_o  output  1  one-cycle completion pulse.
- mdu_stall_o  output  1  pipeline hold request.

Behaviour:
- Reset: async, active high. state=IDLE; ack_o=0, result_o=0, all internal registers 0. mdu_stall_o is combinational: enable_i & ~ack_o & ~kill_i. It therefore reads 0 during reset when enable_i=0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE -> MUL when enable_i & ~kill_i & ~op[2].
- IDLE -> DIV when enable_i & ~kill_i & op[2].
- IDLE -> DONE on a fast-corner divide.
- MUL/DIV -> DONE when the iteration counter reaches 31. MUL/DIV -> IDLE on kill_i.
- DONE -> IDLE always. The pulse ack_o=1 occurs only in DONE.
- Accept edge E0 (IDLE):
  - Latch op.
  - Compute operand signs: rs1 signed for MUL/MULH/MULHSU/DIV/REM; rs2 signed for MULH/DIV/REM.
  - Store operand magnitudes and the result-negate flags.
  - Clear the 5-bit counter and the 64-bit accumulator.
- Iterations E1..E32, one bit per cycle:
  - MUL: shift-add, LSB-first over the rs2 magnitude.
  - DIV: restoring shift-subtract, MSB-first. Quotient and remainder are 32 bits each.
- Edge E33 registers the final result. ack_o is high in the cycle following E33, so latency is 34 cycles from accept to ack cycle.
- Result select:
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Sign fix-ups:
  - Product is negated (two's complement, 64-bit) when sign1 XOR sign2.
  - Quotient is negated when the signed dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
- Fast corners (FAST_DIV_CORNER=1), taken at E0 straight to DONE with ack in the next cycle:
  - Divisor == 0: quotient=32'hFFFFFFFF, remainder=rs1.
  - Signed DIV/REM with rs1=32'h80000000 and rs2=32'hFFFFFFFF: quotient=32'h80000000, remainder=0.
- Handshake:
  - In the DONE cycle, stall_o=0, so the pipeline advances on that edge.
  - DONE never accepts, so back-to-back ops have 1 idle cycle.
  - ack_o and result_o are registered. result_o holds its last value after ack.
- Kill:
  - kill_i in any state forces IDLE on the next edge with no ack.
  - kill_i in DONE suppresses nothing: ack is already registered, and the pipeline must ignore it.
  - kill_i and enable_i together in IDLE: no accept.
- enable_i dropping without kill mid-operation is illegal; the behaviour is undefined.
- Reset mid-operation returns to IDLE immediately with ack_o=0.

Test Plan:
- MUL 7 × -3, enable held -> stall high 34 cycles; ack on 35th cycle after raise; result 32'hFFFFFFEB.
- MULHU FFFFFFFF × FFFFFFFF -> result FFFFFFFE. MULH same operands -> 00000000. MULHSU FFFFFFFF × 2 -> FFFFFFFF.
- DIV -7 / 2 -> 32'hFFFFFFFD. REM -7 / 2 -> 32'hFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> ack 1 cycle after accept, result FFFFFFFF. REM 80000000 / FFFFFFFF -> fast ack, result 0. Repeat with FAST_DIV_CORNER=0 -> same results at full latency.
- Kill at iteration 10 of DIV -> no ack, IDLE next cycle. New MUL 3×4 issued 1 cycle later -> result 12, full latency.
- Assert rst_i at iteration 20 -> ack_o=0 immediately. After release with enable_i=0, stall_o=0 and no spurious ack.

Source files
------------

// File: rtl/mirfak_mdu_ctrl.sv
// mirfak_mdu_ctrl: sequenced RV32M multiply/divide unit for the execute stage.
// One op at a time; 32 single-bit iterations over a shared 64-bit accumulator.
// Multiply is LSB-first shift-add, divide is MSB-first restoring shift-subtract.
module mirfak_mdu_ctrl #(
  parameter bit ENABLE_MULTDIV  = 1'b1,
  parameter bit FAST_DIV_CORNER = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  mdu_op_i,
  input  logic [31:0] mdu_dat1_i,
  input  logic [31:0] mdu_dat2_i,
  input  logic        mdu_enable_i,
  input  logic        mdu_kill_i,
  output logic [31:0] mdu_result_o,
  output logic        mdu_ack_o,
  output logic        mdu_stall_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;        // rs1 magnitude
  logic [31:0] b_q, b_d;        // rs2 magnitude
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        last_q, last_d;  // all 32 iterations done, next cycle finalizes
  logic        neg_q, neg_d;    // negate product / quotient
  logic        negr_q, negr_d;  // negate remainder (dividend sign)
  logic        ack_q, ack_d;
  logic [31:0] res_q, res_d;

  // operand decode at accept
  logic        s1_en, s2_en, sgn1, sgn2, div0_in, ovf_in, fast;
  logic [31:0] mag1, mag2, fast_res;
  // iteration datapath
  logic [32:0] mul_sum, div_sh, div_rem;
  logic        div_ge;
  logic [63:0] mul_next, div_next, prod;
  logic [31:0] quo, rem, final_res;

  // Operand signs/magnitudes and the corner-case shortcut, from live inputs.
  always_comb begin
    s1_en    = !(mdu_op_i == 3'b011 || mdu_op_i == 3'b101 || mdu_op_i == 3'b111);
    s2_en    = (mdu_op_i == 3'b001 || mdu_op_i == 3'b100 || mdu_op_i == 3'b110);
    sgn1     = s1_en & mdu_dat1_i[31];
    sgn2     = s2_en & mdu_dat2_i[31];
    mag1     = sgn1 ? (~mdu_dat1_i + 32'd1) : mdu_dat1_i;
    mag2     = sgn2 ? (~mdu_dat2_i + 32'd1) : mdu_dat2_i;
    div0_in  = (mdu_dat2_i == 32'd0);
    ovf_in   = !mdu_op_i[0] && mdu_dat1_i == 32'h8000_0000 && mdu_dat2_i == 32'hFFFF_FFFF;
    fast     = FAST_DIV_CORNER && mdu_op_i[2] && (div0_in || ovf_in);
    if (div0_in) fast_res = mdu_op_i[1] ? mdu_dat1_i : 32'hFFFF_FFFF;
    else         fast_res = mdu_op_i[1] ? 32'd0 : 32'h8000_0000;
  end

  // One iteration step for each datapath and the signed result select.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (b_q[cnt_q] ? a_q : 32'd0)};
    mul_next = {mul_sum, acc_q[31:1]};
    // remainder < divisor always holds, so 33 bits cover the shifted value
    div_sh   = {acc_q[63:32], a_q[~cnt_q]};
    div_ge   = (div_sh >= {1'b0, b_q});
    div_rem  = div_ge ? (div_sh - {1'b0, b_q}) : div_sh;
    div_next = {div_rem[31:0], acc_q[30:0], div_ge};
    prod     = neg_q ? (~acc_q + 64'd1) : acc_q;
    quo      = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem      = negr_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    case (op_q)
      3'b000:                 final_res = prod[31:0];
      3'b001, 3'b010, 3'b011: final_res = prod[63:32];
      3'b100, 3'b101:         final_res = quo;
      default:                final_res = rem;
    endcase
  end

  // Next-state logic for the FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    res_d   = res_q;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ENABLE_MULTDIV && mdu_enable_i && !mdu_kill_i) begin
          op_d   = mdu_op_i;
          // divide-by-zero must give all-ones regardless of dividend sign
          neg_d  = (sgn1 ^ sgn2) & !(mdu_op_i[2] && div0_in);
          negr_d = sgn1;
          a_d    = mag1;
          b_d    = mag2;
          acc_d  = 64'd0;
          cnt_d  = 5'd0;
          last_d = 1'b0;
          if (fast) begin
            state_d = S_DONE;
            ack_d   = 1'b1;
            res_d   = fast_res;
          end else begin
            state_d = mdu_op_i[2] ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (mdu_kill_i) begin
          state_d = S_IDLE;
        end else if (last_q) begin
          state_d = S_DONE;
          ack_d   = 1'b1;
          res_d   = final_res;
        end else begin
          acc_d  = (state_q == S_MUL) ? mul_next : div_next;
          cnt_d  = cnt_q + 5'd1;
          last_d = (cnt_q == 5'd31);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; async reset clears everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
      last_q  <= 1'b0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      ack_q   <= 1'b0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      ack_q   <= ack_d;
      res_q   <= res_d;
    end
  end

  assign mdu_ack_o    = ack_q;
  assign mdu_result_o = res_q;
  assign mdu_stall_o  = ENABLE_MULTDIV && mdu_enable_i && !ack_q && !mdu_kill_i;

endmodule

// File: tb/tb_mirfak_mdu_ctrl.sv
// Scoreboard bench for mirfak_mdu_ctrl: one instance with fast divide corners,
// one without. Drivers push expected results; per-instance monitors pop on ack.
module tb_mirfak_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic [31:0] d1, d2;
  logic        en_f, en_s, kill;
  logic [31:0] res_f, res_s;
  logic        ack_f, ack_s, stall_f, stall_s;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] res;
    int          issue;
    int          lat;
    string       name;
  } exp_t;

  exp_t q_f[$];
  exp_t q_s[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mirfak_mdu_ctrl #(.ENABLE_MULTDIV(1'b1), .FAST_DIV_CORNER(1'b1)) dut_f (
    .clk_i(clk), .rst_i(rst), .mdu_op_i(op), .mdu_dat1_i(d1), .mdu_dat2_i(d2),
    .mdu_enable_i(en_f), .mdu_kill_i(kill), .mdu_result_o(res_f),
    .mdu_ack_o(ack_f), .mdu_stall_o(stall_f));

  mirfak_mdu_ctrl #(.ENABLE_MULTDIV(1'b1), .FAST_DIV_CORNER(1'b0)) dut_s (
    .clk_i(clk), .rst_i(rst), .mdu_op_i(op), .mdu_dat1_i(d1), .mdu_dat2_i(d2),
    .mdu_enable_i(en_s), .mdu_kill_i(kill), .mdu_result_o(res_s),
    .mdu_ack_o(ack_s), .mdu_stall_o(stall_s));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitors: compare result and accept-to-ack latency on every ack
  always @(negedge clk) begin
    if (!rst && ack_f) begin
      if (q_f.size() == 0) check("fast spurious ack", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q_f.pop_front();
        check({"fast res ", e.name}, res_f, e.res);
        check({"fast lat ", e.name}, cyc - e.issue, e.lat);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ack_s) begin
      if (q_s.size() == 0) check("slow spurious ack", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q_s.pop_front();
        check({"slow res ", e.name}, res_s, e.res);
        check({"slow lat ", e.name}, cyc - e.issue, e.lat);
      end
    end
  end

  // issue one op to one instance, hold enable until ack, check stall length
  task automatic run_op(input bit sel, input string name, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    exp_t e;
    int   stall_cnt;
    bit   got;
    @(negedge clk);
    op = o; d1 = a; d2 = b;
    e.res = exp; e.issue = cyc; e.lat = lat; e.name = name;
    if (sel) begin en_s = 1'b1; q_s.push_back(e); end
    else     begin en_f = 1'b1; q_f.push_back(e); end
    #1;
    stall_cnt = (sel ? stall_s : stall_f) ? 1 : 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (sel ? ack_s : ack_f) got = 1'b1;
      else if (sel ? stall_s : stall_f) stall_cnt++;
    end
    if (!got) begin
      check({"ack timeout ", name}, 32'd0, 32'd1);
      if (sel) void'(q_s.pop_back()); else void'(q_f.pop_back());
    end else begin
      check({"stall in ack cycle ", name}, {31'd0, sel ? stall_s : stall_f}, 32'd0);
    end
    check({"stall cycles ", name}, stall_cnt, lat);
    en_f = 1'b0; en_s = 1'b0;
  endtask

  localparam int NV = 14;
  logic [2:0]  t_op  [NV] = '{3'b000, 3'b011, 3'b001, 3'b010, 3'b100, 3'b110, 3'b101,
                              3'b111, 3'b101, 3'b110, 3'b100, 3'b111, 3'b100, 3'b110};
  logic [31:0] t_a   [NV] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd5,
                              32'h80000000, 32'h80000000, 32'd5, 32'hFFFFFFF9, 32'hFFFFFFF9};
  logic [31:0] t_b   [NV] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,
                              32'd0, 32'd0};
  logic [31:0] t_exp [NV] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF,
                              32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF,
                              32'h00000000, 32'h80000000, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF9};
  bit          t_crn [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  string       t_nm  [NV] = '{"mul 7*-3", "mulhu -1*-1", "mulh -1*-1", "mulhsu -1*2",
                              "div -7/2", "rem -7/2", "divu 100/7", "remu 100/7",
                              "divu 5/0", "rem ovf", "div ovf", "remu 5/0",
                              "div -7/0", "rem -7/0"};

  initial begin
    rst = 1'b1; op = 3'd0; d1 = 32'd0; d2 = 32'd0;
    en_f = 1'b0; en_s = 1'b0; kill = 1'b0;
    #1;
    check("reset ack", {31'd0, ack_f}, 32'd0);
    check("reset result", res_f, 32'd0);
    check("reset stall", {31'd0, stall_f}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++)
      run_op(1'b0, t_nm[i], t_op[i], t_a[i], t_b[i], t_exp[i], t_crn[i] ? 1 : 34);
    for (int i = 0; i < NV; i++)
      run_op(1'b1, t_nm[i], t_op[i], t_a[i], t_b[i], t_exp[i], 34);

    // kill DIV at iteration 10: no ack, then a fresh MUL completes normally
    @(negedge clk);
    op = 3'b100; d1 = 32'd1000; d2 = 32'd3; en_f = 1'b1;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    #1 check("stall under kill", {31'd0, stall_f}, 32'd0);
    @(negedge clk);
    kill = 1'b0; en_f = 1'b0;
    check("no ack after kill", {31'd0, ack_f}, 32'd0);
    run_op(1'b0, "mul 3*4 after kill", 3'b000, 32'd3, 32'd4, 32'd12, 34);

    // reset at iteration 20 of a slow MUL
    @(negedge clk);
    op = 3'b000; d1 = 32'd9; d2 = 32'd9; en_s = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1; en_s = 1'b0;
    #1;
    check("ack in mid-op reset", {31'd0, ack_s}, 32'd0);
    check("result in mid-op reset", res_s, 32'd0);
    check("stall in mid-op reset", {31'd0, stall_s}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("stall after reset release", {31'd0, stall_s}, 32'd0);

    check("fast queue drained", q_f.size(), 32'd0);
    check("slow queue drained", q_s.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
